dual_issue_pair_scheduler: RTL and testbench

- Sits between the IF_ID register and the decode stage of the dual-issue core.
- Takes each fetched instruction pair and checks it for intra-pair conflicts (RAW, WAW, dual memory access, control in slot 1).
- Conflict-free pairs issue together. On a conflict, slot 1 issues alone and slot 2 is held and replayed the next cycle as a single issue.
- Provides a fetch handshake, decode back-pressure, redirect flush and issue statistics.

---
 rtl/dual_issue_pair_scheduler.sv | 117 +++++++++++
 tb/tb_dual_issue_pair_scheduler.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/dual_issue_pair_scheduler.sv
// dual_issue_pair_scheduler: issues fetch pairs together, splitting those with intra-pair hazards into two single issues
module dual_issue_pair_scheduler #(
    parameter int PC_W  = 11,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr1,
    input  logic [31:0]      in_instr2,
    input  logic [PC_W-1:0]  in_pc,
    input  logic             stall_in,
    input  logic             flush,
    output logic             out_valid1,
    output logic             out_valid2,
    output logic [31:0]      out_instr1,
    output logic [31:0]      out_instr2,
    output logic [PC_W-1:0]  out_pc1,
    output logic [PC_W-1:0]  out_pc2,
    output logic [CNT_W-1:0] pair_count,
    output logic [CNT_W-1:0] split_count
);
    typedef enum logic {PAIR, HOLD} stateT;
    stateT state;
    logic [31:0] holdInstr;
    logic [PC_W-1:0] holdPc;
    logic [4:0] dest1, dest2;
    logic raw, conflict;

    // Destination register; zero doubles as "no write", which also makes writes to r0 harmless
    function automatic logic [4:0] destOf(input logic [31:0] i);
        logic [5:0] op;
        op = i[31:26];
        return op == 6'h00 ? (i[5:0] == 6'h08 ? 5'd0 : i[15:11]) :
               (op == 6'h2B || op == 6'h04 || op == 6'h05 || op == 6'h02) ? 5'd0 :
               op == 6'h03 ? 5'd31 : i[20:16];
    endfunction

    function automatic logic readsRs(input logic [31:0] i);
        return i[31:26] != 6'h02 && i[31:26] != 6'h03;
    endfunction

    function automatic logic readsRt(input logic [31:0] i);
        logic [5:0] op;
        op = i[31:26];
        return (op == 6'h00 && i[5:0] != 6'h08) || op == 6'h2B || op == 6'h04 || op == 6'h05;
    endfunction

    function automatic logic isMem(input logic [31:0] i);
        return i[31:26] == 6'h23 || i[31:26] == 6'h2B;
    endfunction

    function automatic logic isCtrl(input logic [31:0] i);
        logic [5:0] op;
        op = i[31:26];
        return op == 6'h04 || op == 6'h05 || op == 6'h02 || op == 6'h03 || (op == 6'h00 && i[5:0] == 6'h08);
    endfunction

    assign dest1 = destOf(in_instr1);
    assign dest2 = destOf(in_instr2);
    assign raw = (readsRs(in_instr2) && dest1 == in_instr2[25:21]) || (readsRt(in_instr2) && dest1 == in_instr2[20:16]);
    assign conflict = (dest1 != 5'd0 && (raw || dest1 == dest2)) || (isMem(in_instr1) && isMem(in_instr2)) || isCtrl(in_instr1);
    assign in_ready = state == PAIR && !stall_in && !flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= PAIR;
            holdInstr   <= '0;
            holdPc      <= '0;
            out_valid1  <= 1'b0;
            out_valid2  <= 1'b0;
            out_instr1  <= '0;
            out_instr2  <= '0;
            out_pc1     <= '0;
            out_pc2     <= '0;
            pair_count  <= '0;
            split_count <= '0;
        end else if (flush) begin
            state      <= PAIR;
            holdInstr  <= '0;
            holdPc     <= '0;
            out_valid1 <= 1'b0;
            out_valid2 <= 1'b0;
        end else if (!stall_in) begin
            if (state == HOLD) begin
                state      <= PAIR;
                out_valid1 <= 1'b1;
                out_valid2 <= 1'b0;
                out_instr1 <= holdInstr;
                out_instr2 <= '0;
                out_pc1    <= holdPc;
                out_pc2    <= '0;
                holdInstr  <= '0;
                holdPc     <= '0;
            end else if (in_valid) begin
                out_valid1 <= 1'b1;
                out_valid2 <= !conflict;
                out_instr1 <= in_instr1;
                out_instr2 <= conflict ? 32'd0 : in_instr2;
                out_pc1    <= in_pc;
                out_pc2    <= conflict ? '0 : in_pc + 1'b1;
                if (conflict) begin
                    state       <= HOLD;
                    holdInstr   <= in_instr2;
                    holdPc      <= in_pc + 1'b1;
                    split_count <= split_count + CNT_W'(split_count != '1);
                end else begin
                    pair_count <= pair_count + CNT_W'(pair_count != '1);
                end
            end else begin
                out_valid1 <= 1'b0;
                out_valid2 <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dual_issue_pair_scheduler.sv
// tb_dual_issue_pair_scheduler: directed steps with a scoreboard of expected issue slots
module tb_dual_issue_pair_scheduler;
    logic clk = 1'b0, rst = 1'b0, inValid = 1'b0, stallIn = 1'b0, flush = 1'b0;
    logic [31:0] inInstr1 = '0, inInstr2 = '0;
    logic [10:0] inPc = '0;
    logic inReady, outValid1, outValid2;
    logic [31:0] outInstr1, outInstr2;
    logic [10:0] outPc1, outPc2;
    logic [15:0] pairCount, splitCount;
    logic sReady, sValid1, sValid2;
    logic [31:0] sInstr1, sInstr2;
    logic [10:0] sPc1, sPc2;
    logic [1:0] sPair, sSplit;
    int nVec = 0, nFail = 0;
    logic [15:0] expP = '0, expS = '0;

    typedef struct {
        logic v1, v2, z2;
        logic [31:0] i1, i2;
        logic [10:0] p1, p2;
        logic [15:0] pc, sc;
    } expT;
    expT sb[$];

    always #5 clk = ~clk;

    dual_issue_pair_scheduler dut (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
        .in_instr1(inInstr1), .in_instr2(inInstr2), .in_pc(inPc),
        .stall_in(stallIn), .flush(flush),
        .out_valid1(outValid1), .out_valid2(outValid2),
        .out_instr1(outInstr1), .out_instr2(outInstr2),
        .out_pc1(outPc1), .out_pc2(outPc2),
        .pair_count(pairCount), .split_count(splitCount)
    );

    dual_issue_pair_scheduler #(.PC_W(11), .CNT_W(2)) dutSmall (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(sReady),
        .in_instr1(inInstr1), .in_instr2(inInstr2), .in_pc(inPc),
        .stall_in(stallIn), .flush(flush),
        .out_valid1(sValid1), .out_valid2(sValid2),
        .out_instr1(sInstr1), .out_instr2(sInstr2),
        .out_pc1(sPc1), .out_pc2(sPc2),
        .pair_count(sPair), .split_count(sSplit)
    );

    function automatic logic [31:0] rIns(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] iIns(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check in_ready before the edge, then score the registered outputs
    task automatic step(input string tag, input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [10:0] pc, input logic st, input logic fl, input logic rdy,
                        input logic ev1, input logic ev2, input logic z2,
                        input logic [31:0] ei1, input logic [31:0] ei2,
                        input logic [10:0] ep1, input logic [10:0] ep2);
        expT e, o;
        inValid = v; inInstr1 = a; inInstr2 = b; inPc = pc; stallIn = st; flush = fl;
        #1;
        chk({tag, ".in_ready"}, 32'(inReady), 32'(rdy));
        e.v1 = ev1; e.v2 = ev2; e.z2 = z2; e.i1 = ei1; e.i2 = ei2; e.p1 = ep1; e.p2 = ep2;
        e.pc = expP; e.sc = expS;
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        chk({tag, ".valid1"}, 32'(outValid1), 32'(o.v1));
        chk({tag, ".valid2"}, 32'(outValid2), 32'(o.v2));
        if (o.v1) begin
            chk({tag, ".instr1"}, outInstr1, o.i1);
            chk({tag, ".pc1"}, 32'(outPc1), 32'(o.p1));
        end
        if (o.v2) begin
            chk({tag, ".instr2"}, outInstr2, o.i2);
            chk({tag, ".pc2"}, 32'(outPc2), 32'(o.p2));
        end
        if (o.z2) chk({tag, ".instr2_zero"}, outInstr2, 32'd0);
        chk({tag, ".pair_count"}, 32'(pairCount), 32'(o.pc));
        chk({tag, ".split_count"}, 32'(splitCount), 32'(o.sc));
    endtask

    initial begin
        logic [31:0] add3, sub5, addi7, add8, lw2, sw3, addi4a, addi4b, add0a, add0b, beq12, add9, jr31, xA, xB;
        add3 = rIns(1, 2, 3, 'h20);     sub5 = rIns(4, 6, 5, 'h22);
        addi7 = iIns('h08, 0, 7, 5);    add8 = rIns(7, 1, 8, 'h20);
        lw2 = iIns('h23, 1, 2, 0);      sw3 = iIns('h2B, 1, 3, 4);
        addi4a = iIns('h08, 1, 4, 1);   addi4b = iIns('h08, 2, 4, 2);
        add0a = rIns(1, 2, 0, 'h20);    add0b = rIns(0, 3, 0, 'h20);
        beq12 = iIns('h04, 1, 2, 4);    add9 = rIns(1, 2, 9, 'h20);
        jr31 = rIns(31, 0, 0, 'h08);
        xA = rIns(11, 12, 10, 'h20);    xB = rIns(13, 14, 15, 'h22);

        rst = 1'b0;
        step("reset", 1, add3, sub5, 11'h010, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset.instr1", outInstr1, 0); chk("reset.instr2", outInstr2, 0);
        chk("reset.pc1", 32'(outPc1), 0);  chk("reset.pc2", 32'(outPc2), 0);
        rst = 1'b1;

        expP = 1;
        step("dual", 1, add3, sub5, 11'h010, 0, 0, 1, 1, 1, 0, add3, sub5, 11'h010, 11'h011);
        expS = 1;
        step("raw", 1, addi7, add8, 11'h020, 0, 0, 1, 1, 0, 1, addi7, 0, 11'h020, 0);
        step("raw.hold", 1, xA, xB, 11'h022, 0, 0, 0, 1, 0, 0, add8, 0, 11'h021, 0);
        expS = 2;
        step("mem", 1, lw2, sw3, 11'h030, 0, 0, 1, 1, 0, 1, lw2, 0, 11'h030, 0);
        step("mem.hold", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, sw3, 0, 11'h031, 0);
        expS = 3;
        step("waw", 1, addi4a, addi4b, 11'h040, 0, 0, 1, 1, 0, 1, addi4a, 0, 11'h040, 0);
        step("waw.hold", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, addi4b, 0, 11'h041, 0);
        expP = 2;
        step("r0", 1, add0a, add0b, 11'h050, 0, 0, 1, 1, 1, 0, add0a, add0b, 11'h050, 11'h051);
        step("bubble", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        expS = 4;
        step("beq", 1, beq12, add9, 11'h060, 0, 0, 1, 1, 0, 1, beq12, 0, 11'h060, 0);
        step("beq.flush", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("beq.after", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        expS = 5;
        step("wrap.split", 1, addi7, add8, 11'h7FF, 0, 0, 1, 1, 0, 1, addi7, 0, 11'h7FF, 0);
        for (int k = 0; k < 3; k++)
            step("stall", 1, xA, xB, 11'h123, 1, 0, 0, 1, 0, 1, addi7, 0, 11'h7FF, 0);
        step("stall.release", 1, xA, xB, 11'h123, 0, 0, 0, 1, 0, 0, add8, 0, 11'h000, 0);
        expP = 3;
        step("wrap.dual", 1, add3, sub5, 11'h7FF, 0, 0, 1, 1, 1, 0, add3, sub5, 11'h7FF, 11'h000);
        step("flush_stall", 1, add3, sub5, 11'h070, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        expS = 6;
        step("jr", 1, jr31, add9, 11'h300, 0, 0, 1, 1, 0, 1, jr31, 0, 11'h300, 0);
        step("jr.hold", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, add9, 0, 11'h301, 0);
        expP = 4;
        step("dual4", 1, add3, sub5, 11'h200, 0, 0, 1, 1, 1, 0, add3, sub5, 11'h200, 11'h201);
        chk("small.pair_sat", 32'(sPair), 3);
        chk("small.split_sat", 32'(sSplit), 3);
        expS = 7;
        step("mid.split", 1, lw2, sw3, 11'h100, 0, 0, 1, 1, 0, 1, lw2, 0, 11'h100, 0);
        rst = 1'b0;
        expP = 0; expS = 0;
        step("mid.reset", 1, add3, sub5, 11'h110, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("mid.reset.instr1", outInstr1, 0);
        chk("mid.reset.pc1", 32'(outPc1), 0);
        chk("small.reset_pair", 32'(sPair), 0);
        rst = 1'b1;
        step("mid.lost", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end
endmodule
